cache_main_mem: RTL and testbench
=================================

# cache_main_mem

Line-granular backing memory model that sits directly downstream of the L1 cache's memory port. It accepts one read-line or write-line request at a time on the `mem_r_req_bus_t` / `mem_w_req_bus_t` channels, applies a fixed programmable access latency, and returns a 128-bit line or a write acknowledge. Storage is 2^(ADDR_WIDTH-OFFSET_WIDTH) lines of DATA_WIDTH_M bits, which is 16 × 128 b with the package defaults.

## Interface
- `LATENCY`, default 4: cycles from request acceptance to the response pulse; legal range 1..15.
- `clk`  in  1  clock; all logic updates on the rising edge.
- `rstn`  in  1  synchronous, active-low reset.
- `mem_r_req_valid`  in  1  read request present.
- `mem_r_req`  in  `mem_r_req_bus_t`  line address.
- `mem_r_req_ready`  out  1  read request accepted this cycle when valid && ready.
- `mem_r_resp_valid`  out  1  one-cycle read response pulse.
- `mem_r_resp`  out  `mem_r_resp_bus_t`  line data and rresp.
- `mem_w_req_valid`  in  1  write request present.
- `mem_w_req`  in  `mem_w_req_bus_t`  address, 128-bit data, 16-bit byte mask.
- `mem_w_req_ready`  out  1  write request accepted this cycle when valid && ready.
- `mem_w_resp_valid`  out  1  one-cycle write acknowledge pulse.
- `mem_w_resp`  out  `mem_w_resp_bus_t`  bresp.

## Operation
- FSM states: IDLE, BUSY, RESP. Reset enters IDLE.
- IDLE:
  - Both ready outputs are 1.
  - If `mem_w_req_valid`, accept the write; write wins when both channels are valid, and the read ready drops to 0 that cycle.
  - Else if `mem_r_req_valid`, accept the read.
  - On acceptance, latch kind (rd/wr), line index `addr[7:4]`, data and wmask, then go to BUSY.
- BUSY:
  - Both readies are 0.
  - The 4-bit down-counter loads LATENCY-1 at acceptance and decrements each cycle.
  - When the counter is 0, go to RESP. With LATENCY=1, skip BUSY and go straight to RESP.
- RESP:
  - Assert exactly one of the response valids for one cycle.
  - Read: rdata = line[index]; rresp=2'b00.
  - Write: for each i in 0..15, byte i of line[index] is updated from data[8i+7:8i] iff wmask[i]. The update commits at the end of the RESP cycle. bresp=2'b00.
  - Return to IDLE.
- `addr[3:0]` (offset) is ignored, because requests are line-aligned.
- Only one transaction is outstanding at a time. Requests not accepted must be held by the requester.
- Array contents are not cleared by reset and are X until written.

## Timing
- Acceptance edge T; response valid is high during cycle T+LATENCY; ready is high again in cycle T+LATENCY+1.
- Back-to-back throughput: one transaction per LATENCY+1 cycles.
- A read issued after a write to the same line returns the merged data, because the write commits before IDLE.
- Reset values:
  - All ready outputs are 0 while rstn=0 and 1 in the first cycle after release.
  - Response valids are 0.
  - rdata is 0, rresp is 0, bresp is 0.
  - Counter is 0.
- Reset asserted in BUSY or RESP aborts the transaction: no array write, no response pulse.
- Response outputs are registered, with no combinational path from request inputs. Ready outputs are decoded from state only, except the write-priority masking of the read ready.

## Configuration
- `CACHE_MEM_ALIGN_CHECK_EN`
  - Defined: a request with `addr[3:0] != 0` still takes LATENCY cycles, but returns rresp/bresp=2'b10 (SLVERR). A read returns rdata=0. A write leaves the array unchanged.
  - Undefined: offset bits are ignored and resp is always 2'b00.

## Structure
- The shared cache package supplies:
  - the request and response bus structs;
  - the ADDR_WIDTH, DATA_WIDTH_M, OFFSET_WIDTH and INDEX_WIDTH constants;
  - new localparams: `MEM_LINES = 1 << (ADDR_WIDTH-OFFSET_WIDTH)`, `RESP_OKAY=2'b00`, `RESP_SLVERR=2'b10`.
- The FSM state enum lives locally in the module.
- One sub-module: `cache_mem_array`, a 16×128 storage array with a byte-masked synchronous write port and a combinational read port.

## Test plan
- Reset, then write addr 0x20, data 0x00112233_44556677_8899AABB_CCDDEEFF, wmask 0xFFFF → w_resp_valid 1 pulse at T+4. Read 0x20 → identical rdata at T'+4.
- Partial write to addr 0x20 with wmask 0x0001, data byte0=0x5A → next read returns byte0=0x5A, other bytes unchanged.
- Read and write valid in the same cycle to addr 0x30 → write accepted first and r_ready=0. The read is accepted at T+5 and returns the new data.
- LATENCY=1 instance: read accepted at T → r_resp_valid at T+1, ready high at T+2.
- Reset asserted mid-BUSY of a write to 0x40 → no w_resp_valid, and a later read of 0x40 shows the old contents.
- With `CACHE_MEM_ALIGN_CHECK_EN`: read addr 0x25 → rresp=2'b10, rdata=0. A write to 0x25 → bresp=2'b10 and the line is unchanged.

Source files
------------

// File: rtl/cache_main_mem_pkg.sv
// Shared cache package: bus widths, request/response bus structs and
// constants for the line-granular backing memory (cache_main_mem).
package cache_main_mem_pkg;

    localparam int ADDR_WIDTH   = 8;
    localparam int OFFSET_WIDTH = 4;
    localparam int INDEX_WIDTH  = ADDR_WIDTH - OFFSET_WIDTH;
    localparam int DATA_WIDTH_M = 128;
    localparam int WMASK_WIDTH  = DATA_WIDTH_M / 8;
    localparam int MEM_LINES    = 1 << (ADDR_WIDTH - OFFSET_WIDTH);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        REQ_RD = 1'b0,
        REQ_WR = 1'b1
    } req_kind_e;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
    } mem_r_req_bus_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH_M-1:0] data;
        logic [WMASK_WIDTH-1:0]  wmask;
    } mem_w_req_bus_t;

    typedef struct packed {
        logic [DATA_WIDTH_M-1:0] rdata;
        logic [1:0]              rresp;
    } mem_r_resp_bus_t;

    typedef struct packed {
        logic [1:0] bresp;
    } mem_w_resp_bus_t;

    // Line index of a byte address (offset bits dropped).
    function automatic logic [INDEX_WIDTH-1:0] line_index(input logic [ADDR_WIDTH-1:0] addr);
        return addr[ADDR_WIDTH-1:OFFSET_WIDTH];
    endfunction

endpackage

// File: rtl/cache_main_mem_array.sv
// cache_mem_array: MEM_LINES x DATA_WIDTH_M storage, byte-masked synchronous
// write port and combinational read port. Contents are never reset.
module cache_mem_array
    import cache_main_mem_pkg::*;
(
    input  logic                    clk,
    input  logic                    i_we,
    input  logic [INDEX_WIDTH-1:0]  i_waddr,
    input  logic [DATA_WIDTH_M-1:0] i_wdata,
    input  logic [WMASK_WIDTH-1:0]  i_wmask,
    input  logic [INDEX_WIDTH-1:0]  i_raddr,
    output logic [DATA_WIDTH_M-1:0] o_rdata
);

    logic [DATA_WIDTH_M-1:0] r_mem [MEM_LINES];

    // Byte-masked line write.
    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int unsigned i = 0; i < WMASK_WIDTH; i++) begin
                if (i_wmask[i]) begin
                    r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cache_main_mem.sv
// cache_main_mem: single-outstanding line memory behind the L1 memory port.
// One read or write is accepted in IDLE (write has priority), held for
// LATENCY cycles, then answered with a one-cycle registered response.
// Optional macro CACHE_MEM_ALIGN_CHECK_EN: misaligned requests get SLVERR,
// reads return zero data and writes leave the array untouched.
module cache_main_mem
    import cache_main_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            mem_r_req_valid,
    input  mem_r_req_bus_t  mem_r_req,
    output logic            mem_r_req_ready,
    output logic            mem_r_resp_valid,
    output mem_r_resp_bus_t mem_r_resp,
    input  logic            mem_w_req_valid,
    input  mem_w_req_bus_t  mem_w_req,
    output logic            mem_w_req_ready,
    output logic            mem_w_resp_valid,
    output mem_w_resp_bus_t mem_w_resp
);

`ifdef CACHE_MEM_ALIGN_CHECK_EN
    localparam bit ALIGN_CHECK = 1'b1;
`else
    localparam bit ALIGN_CHECK = 1'b0;
`endif

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e                  r_state, w_state_nxt;
    logic [3:0]              r_cnt, w_cnt_nxt;
    logic                    w_accept_wr, w_accept_rd, w_accept;
    logic                    w_offset_nz;
    req_kind_e               r_kind, w_kind_cur;
    logic [INDEX_WIDTH-1:0]  r_index, w_index_cur;
    logic                    r_err, w_err_cur;
    logic [DATA_WIDTH_M-1:0] r_wdata, w_arr_rdata;
    logic [WMASK_WIDTH-1:0]  r_wmask;
    logic                    w_enter_resp, w_arr_we;
    logic                    r_rvalid, r_bvalid;
    logic [DATA_WIDTH_M-1:0] r_rdata;
    logic [1:0]              r_rresp, r_bresp;

    // Request arbitration and selection of the transaction currently in
    // flight; with LATENCY=1 the response is formed from the live request.
    always_comb begin
        w_accept_wr = (r_state == ST_IDLE) && mem_w_req_valid;
        w_accept_rd = (r_state == ST_IDLE) && !mem_w_req_valid && mem_r_req_valid;
        w_accept    = w_accept_wr || w_accept_rd;
        w_kind_cur  = r_kind;
        w_index_cur = r_index;
        w_offset_nz = 1'b0;
        if (w_accept_wr) begin
            w_kind_cur  = REQ_WR;
            w_index_cur = line_index(mem_w_req.addr);
            w_offset_nz = |mem_w_req.addr[OFFSET_WIDTH-1:0];
        end else if (w_accept_rd) begin
            w_kind_cur  = REQ_RD;
            w_index_cur = line_index(mem_r_req.addr);
            w_offset_nz = |mem_r_req.addr[OFFSET_WIDTH-1:0];
        end
        w_err_cur = w_accept ? (ALIGN_CHECK && w_offset_nz) : r_err;
    end

    // Next-state, latency counter and ready decode.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        mem_w_req_ready = 1'b0;
        mem_r_req_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                mem_w_req_ready = rstn;
                mem_r_req_ready = rstn && !mem_w_req_valid;
                if (w_accept) begin
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = (CNT_LOAD == 4'd0) ? ST_RESP : ST_BUSY;
                end
            end
            ST_BUSY: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (w_cnt_nxt == 4'd0) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Latch the accepted request.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_kind  <= REQ_RD;
            r_index <= '0;
            r_err   <= 1'b0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_accept) begin
            r_kind  <= w_kind_cur;
            r_index <= w_index_cur;
            r_err   <= w_err_cur;
            r_wdata <= mem_w_req.data;
            r_wmask <= mem_w_req.wmask;
        end
    end

    assign w_enter_resp = (w_state_nxt == ST_RESP);

    // Registered response: valid/data loaded on the edge entering RESP.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_rvalid <= 1'b0;
            r_bvalid <= 1'b0;
            r_rdata  <= '0;
            r_rresp  <= RESP_OKAY;
            r_bresp  <= RESP_OKAY;
        end else begin
            r_rvalid <= w_enter_resp && (w_kind_cur == REQ_RD);
            r_bvalid <= w_enter_resp && (w_kind_cur == REQ_WR);
            if (w_enter_resp && (w_kind_cur == REQ_RD)) begin
                r_rdata <= w_err_cur ? '0 : w_arr_rdata;
                r_rresp <= w_err_cur ? RESP_SLVERR : RESP_OKAY;
            end
            if (w_enter_resp && (w_kind_cur == REQ_WR)) begin
                r_bresp <= w_err_cur ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // Write commits at the end of RESP; a reset during RESP suppresses it.
    assign w_arr_we = rstn && (r_state == ST_RESP) && (r_kind == REQ_WR) && !r_err;

    cache_mem_array u_array (
        .clk     (clk),
        .i_we    (w_arr_we),
        .i_waddr (r_index),
        .i_wdata (r_wdata),
        .i_wmask (r_wmask),
        .i_raddr (w_index_cur),
        .o_rdata (w_arr_rdata)
    );

    assign mem_r_resp_valid = r_rvalid && rstn;
    assign mem_w_resp_valid = r_bvalid && rstn;
    assign mem_r_resp       = '{rdata: r_rdata, rresp: r_rresp};
    assign mem_w_resp       = '{bresp: r_bresp};

endmodule

// File: tb/tb_cache_main_mem.sv
// Self-checking bench for cache_main_mem: a LATENCY=4 instance exercised with
// directed and random traffic against a line-array model, plus a LATENCY=1
// instance for the minimum-latency timing.
module tb_cache_main_mem;
    import cache_main_mem_pkg::*;

    localparam int LAT = 4;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    logic            r_valid, r_ready, r_resp_valid;
    logic            w_valid, w_ready, w_resp_valid;
    mem_r_req_bus_t  r_req;
    mem_w_req_bus_t  w_req;
    mem_r_resp_bus_t r_resp;
    mem_w_resp_bus_t w_resp;

    logic            r1_valid, r1_ready, r1_resp_valid;
    logic            w1_valid, w1_ready, w1_resp_valid;
    mem_r_req_bus_t  r1_req;
    mem_w_req_bus_t  w1_req;
    mem_r_resp_bus_t r1_resp;
    mem_w_resp_bus_t w1_resp;

    int n_cmp = 0;
    int n_err = 0;
    logic [127:0] model [16];

    cache_main_mem #(.LATENCY(LAT)) dut (
        .clk(clk), .rstn(rstn),
        .mem_r_req_valid(r_valid), .mem_r_req(r_req), .mem_r_req_ready(r_ready),
        .mem_r_resp_valid(r_resp_valid), .mem_r_resp(r_resp),
        .mem_w_req_valid(w_valid), .mem_w_req(w_req), .mem_w_req_ready(w_ready),
        .mem_w_resp_valid(w_resp_valid), .mem_w_resp(w_resp)
    );

    cache_main_mem #(.LATENCY(1)) dut1 (
        .clk(clk), .rstn(rstn),
        .mem_r_req_valid(r1_valid), .mem_r_req(r1_req), .mem_r_req_ready(r1_ready),
        .mem_r_resp_valid(r1_resp_valid), .mem_r_resp(r1_resp),
        .mem_w_req_valid(w1_valid), .mem_w_req(w1_req), .mem_w_req_ready(w1_ready),
        .mem_w_resp_valid(w1_resp_valid), .mem_w_resp(w1_resp)
    );

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Byte i of the line takes the new byte iff mask bit i is set.
    function automatic logic [127:0] merge(input logic [127:0] old, input logic [127:0] d,
                                           input logic [15:0] m);
        logic [127:0] res;
        res = old;
        for (int b = 0; b < 16; b++) begin
            if (m[b]) res[b*8 +: 8] = d[b*8 +: 8];
        end
        return res;
    endfunction

    // One transaction on the LATENCY=4 instance with full timing checks.
    task automatic run_txn(input bit is_wr, input logic [7:0] addr, input logic [127:0] data,
                           input logic [15:0] mask, output logic [127:0] rd, output logic [1:0] resp);
        int unsigned waited;
        logic vld, other, exp_vld, exp_rdy;
        rd   = '0;
        resp = 2'b11;
        @(negedge clk);
        if (is_wr) begin
            w_valid = 1'b1;
            w_req   = '{addr: addr, data: data, wmask: mask};
        end else begin
            r_valid    = 1'b1;
            r_req.addr = addr;
        end
        #1;
        waited = 0;
        while (!(is_wr ? w_ready : r_ready) && waited < 20) begin
            @(negedge clk);
            #1;
            waited++;
        end
        n_cmp++;
        if (waited >= 20) begin
            n_err++;
            $display("FAIL accept_timeout: ready got 0 for 20 cycles, expected 1 (addr %h)", addr);
        end
        @(posedge clk);
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (c == 1) begin
                w_valid = 1'b0;
                r_valid = 1'b0;
            end
            #1;
            vld     = is_wr ? w_resp_valid : r_resp_valid;
            other   = is_wr ? r_resp_valid : w_resp_valid;
            exp_vld = (c == LAT);
            exp_rdy = (c == LAT + 1);
            n_cmp++;
            if (vld !== exp_vld || other !== 1'b0) begin
                n_err++;
                $display("FAIL resp_timing: T+%0d got valid=%b other=%b, expected valid=%b other=0",
                         c, vld, other, exp_vld);
            end
            n_cmp++;
            if (w_ready !== exp_rdy || r_ready !== exp_rdy) begin
                n_err++;
                $display("FAIL ready_timing: T+%0d got w_ready=%b r_ready=%b, expected %b",
                         c, w_ready, r_ready, exp_rdy);
            end
            if (c == LAT) begin
                rd   = r_resp.rdata;
                resp = is_wr ? w_resp.bresp : r_resp.rresp;
            end
        end
    endtask

    task automatic check_read(input string name, input logic [7:0] addr, input logic [127:0] exp_d,
                              input logic [1:0] exp_resp);
        logic [127:0] rd;
        logic [1:0]   resp;
        run_txn(1'b0, addr, '0, '0, rd, resp);
        n_cmp++;
        if (rd !== exp_d || resp !== exp_resp) begin
            n_err++;
            $display("FAIL %s: got rdata=%h rresp=%b, expected rdata=%h rresp=%b",
                     name, rd, resp, exp_d, exp_resp);
        end
    endtask

    task automatic do_write(input string name, input logic [7:0] addr, input logic [127:0] d,
                            input logic [15:0] m, input logic [1:0] exp_resp);
        logic [127:0] rd;
        logic [1:0]   resp;
        run_txn(1'b1, addr, d, m, rd, resp);
        n_cmp++;
        if (resp !== exp_resp) begin
            n_err++;
            $display("FAIL %s: got bresp=%b, expected %b", name, resp, exp_resp);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (w_ready !== 1'b0 || r_ready !== 1'b0 || w1_ready !== 1'b0 || r1_ready !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ready: got w=%b r=%b w1=%b r1=%b, expected all 0",
                     w_ready, r_ready, w1_ready, r1_ready);
        end
        rstn = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (w_ready !== 1'b1 || r_ready !== 1'b1 || r_resp_valid !== 1'b0 || w_resp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL post_reset_hs: got w_rdy=%b r_rdy=%b r_vld=%b w_vld=%b, expected 1 1 0 0",
                     w_ready, r_ready, r_resp_valid, w_resp_valid);
        end
        n_cmp++;
        if (r_resp.rdata !== '0 || r_resp.rresp !== 2'b00 || w_resp.bresp !== 2'b00) begin
            n_err++;
            $display("FAIL post_reset_resp: got rdata=%h rresp=%b bresp=%b, expected 0 00 00",
                     r_resp.rdata, r_resp.rresp, w_resp.bresp);
        end
    endtask

    task automatic test_fill();
        logic [127:0] d;
        for (int l = 0; l < 16; l++) begin
            d = rand128();
            do_write("fill_bresp", 8'(l << 4), d, 16'hFFFF, 2'b00);
            model[l] = d;
        end
    endtask

    task automatic test_full_line();
        logic [127:0] d;
        d = 128'h00112233_44556677_8899AABB_CCDDEEFF;
        do_write("full_write_bresp", 8'h20, d, 16'hFFFF, 2'b00);
        model[2] = d;
        check_read("full_write_readback", 8'h20, model[2], 2'b00);
    endtask

    task automatic test_partial();
        logic [127:0] d;
        d = rand128();
        d[7:0] = 8'h5A;
        do_write("partial_bresp", 8'h20, d, 16'h0001, 2'b00);
        model[2] = merge(model[2], d, 16'h0001);
        check_read("partial_readback", 8'h20, model[2], 2'b00);
    endtask

    task automatic test_back_to_back();
        logic [127:0] d;
        logic exp;
        d = rand128();
        @(negedge clk);
        w_valid = 1'b1;
        w_req   = '{addr: 8'h30, data: d, wmask: 16'hF0F0};
        r_valid = 1'b1;
        r_req.addr = 8'h30;
        #1;
        n_cmp++;
        if (w_ready !== 1'b1 || r_ready !== 1'b0) begin
            n_err++;
            $display("FAIL wr_priority: got w_ready=%b r_ready=%b, expected 1 0", w_ready, r_ready);
        end
        model[3] = merge(model[3], d, 16'hF0F0);
        @(posedge clk);
        for (int c = 1; c <= LAT + 1; c++) begin
            @(negedge clk);
            if (c == 1) w_valid = 1'b0;
            #1;
            exp = (c == LAT + 1);
            n_cmp++;
            if (r_ready !== exp || w_resp_valid !== (c == LAT)) begin
                n_err++;
                $display("FAIL b2b_wr_phase: T+%0d got r_ready=%b w_resp_valid=%b, expected %b %b",
                         c, r_ready, w_resp_valid, exp, (c == LAT));
            end
        end
        @(posedge clk);
        for (int c = 1; c <= LAT; c++) begin
            @(negedge clk);
            if (c == 1) r_valid = 1'b0;
            #1;
            n_cmp++;
            if (r_resp_valid !== (c == LAT)) begin
                n_err++;
                $display("FAIL b2b_rd_valid: T+%0d got %b, expected %b", c, r_resp_valid, (c == LAT));
            end
            if (c == LAT) begin
                n_cmp++;
                if (r_resp.rdata !== model[3]) begin
                    n_err++;
                    $display("FAIL b2b_rd_data: got %h, expected %h", r_resp.rdata, model[3]);
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        logic [127:0] d;
        d = rand128();
        @(negedge clk);
        w_valid = 1'b1;
        w_req   = '{addr: 8'h40, data: d, wmask: 16'hFFFF};
        #1;
        n_cmp++;
        if (w_ready !== 1'b1) begin
            n_err++;
            $display("FAIL abort_accept: got w_ready=%b, expected 1", w_ready);
        end
        @(posedge clk);
        @(negedge clk);
        w_valid = 1'b0;
        @(negedge clk);
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (w_resp_valid !== 1'b0) begin
                n_err++;
                $display("FAIL abort_no_resp: cycle %0d got w_resp_valid=%b, expected 0", c, w_resp_valid);
            end
        end
        check_read("abort_old_contents", 8'h40, model[4], 2'b00);
    endtask

    task automatic test_align();
        logic [127:0] d;
        d = rand128();
`ifdef CACHE_MEM_ALIGN_CHECK_EN
        check_read("misaligned_read", 8'h25, 128'h0, 2'b10);
        do_write("misaligned_write_bresp", 8'h25, d, 16'hFFFF, 2'b10);
`else
        check_read("offset_ignored_read", 8'h25, model[2], 2'b00);
        do_write("offset_ignored_write_bresp", 8'h25, d, 16'hFFFF, 2'b00);
        model[2] = d;
`endif
        check_read("align_line_contents", 8'h20, model[2], 2'b00);
    endtask

    task automatic test_random();
        logic [127:0] d;
        logic [15:0]  m;
        logic [7:0]   a;
        int unsigned  line;
        for (int n = 0; n < 40; n++) begin
            line = $urandom_range(0, 15);
`ifdef CACHE_MEM_ALIGN_CHECK_EN
            a = 8'(line << 4);
`else
            a = 8'((line << 4) | $urandom_range(0, 15));
`endif
            if ($urandom_range(0, 1) == 1) begin
                d = rand128();
                m = 16'($urandom);
                do_write("rand_write_bresp", a, d, m, 2'b00);
                model[line] = merge(model[line], d, m);
            end else begin
                check_read("rand_read", a, model[line], 2'b00);
            end
        end
    endtask

    task automatic test_latency1();
        logic [127:0] d;
        d = rand128();
        @(negedge clk);
        w1_valid = 1'b1;
        w1_req   = '{addr: 8'h50, data: d, wmask: 16'hFFFF};
        #1;
        n_cmp++;
        if (w1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL lat1_w_accept: got w_ready=%b, expected 1", w1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        w1_valid = 1'b0;
        #1;
        n_cmp++;
        if (w1_resp_valid !== 1'b1 || w1_ready !== 1'b0 || w1_resp.bresp !== 2'b00) begin
            n_err++;
            $display("FAIL lat1_w_resp: got valid=%b ready=%b bresp=%b, expected 1 0 00",
                     w1_resp_valid, w1_ready, w1_resp.bresp);
        end
        @(negedge clk);
        r1_valid   = 1'b1;
        r1_req.addr = 8'h50;
        #1;
        n_cmp++;
        if (w1_resp_valid !== 1'b0 || r1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL lat1_w_done: got w_valid=%b r_ready=%b, expected 0 1", w1_resp_valid, r1_ready);
        end
        @(posedge clk);
        @(negedge clk);
        r1_valid = 1'b0;
        #1;
        n_cmp++;
        if (r1_resp_valid !== 1'b1 || r1_resp.rdata !== d || r1_resp.rresp !== 2'b00) begin
            n_err++;
            $display("FAIL lat1_r_resp: got valid=%b rdata=%h rresp=%b, expected 1 %h 00",
                     r1_resp_valid, r1_resp.rdata, r1_resp.rresp, d);
        end
        @(negedge clk);
        #1;
        n_cmp++;
        if (r1_resp_valid !== 1'b0 || r1_ready !== 1'b1) begin
            n_err++;
            $display("FAIL lat1_r_done: got valid=%b ready=%b, expected 0 1", r1_resp_valid, r1_ready);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn     = 1'b0;
        r_valid  = 1'b0;
        w_valid  = 1'b0;
        r_req    = '0;
        w_req    = '0;
        r1_valid = 1'b0;
        w1_valid = 1'b0;
        r1_req   = '0;
        w1_req   = '0;
        test_reset();
        test_fill();
        test_full_line();
        test_partial();
        test_back_to_back();
        test_reset_abort();
        test_align();
        test_random();
        test_latency1();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
